alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Next-generation datapath ALU: parametrised width, registered result, valid/ready input handshake.
//  Single-cycle logic/arith ops plus iterative multiply/divide writing internal HI/LO registers.
//  Sits in EX stage; the pipeline stalls while in_ready=0.
// PARAMETERS
//  WIDTH     32   operand/result width (>=8, even)
//  CNT_W     $clog2(WIDTH)+1   iteration counter width (derived, not overridden)
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      unit can accept; transfer when in_valid&&in_ready
//  op         in   4      operation select (see BEHAVIOUR)
//  a, b       in   WIDTH  operands (a=rs/dividend, b=rt/divisor)
//  out_valid  out  1      y/zero/ovf valid this cycle (1-cycle pulse, no backpressure)
//  y          out  WIDTH  registered result
//  zero       out  1      y==0, same cycle as out_valid
//  ovf        out  1      signed overflow, ADD/SUB only, else 0
//  hi, lo     out  WIDTH  HI/LO register contents
// BEHAVIOUR
//  Reset: y=0, zero=0, ovf=0, out_valid=0, hi=0, lo=0, in_ready=1, state=IDLE.
//  op: 0 AND,1 OR,2 ADD,3 SUB(a+~b+1),4 SLT signed,5 NOR,6 XOR,7 SLTU,8 MULTU,9 DIVU,
//      A MULT,B DIV (signed, macro-gated),C MFHI(y=hi),D MFLO(y=lo),E/F illegal.
//  States: IDLE, MUL, DIV, FIX (signed only), DONE.
//  IDLE: in_ready=1. Single-cycle op accepted at edge k -> y/zero/ovf loaded, out_valid=1 in cycle k+1;
//   stays IDLE, so back-to-back single-cycle ops give throughput 1/cycle.
//  MULTU/DIVU accepted -> MUL/DIV, in_ready=0, counter=WIDTH; one shift-add / restoring-subtract step per cycle.
//  After WIDTH iterations -> DONE: hi/lo written on that edge; DONE cycle asserts out_valid, y=lo;
//   next edge -> IDLE. out_valid first high WIDTH+1 cycles after accept edge (33 for WIDTH=32).
//  MULTU: {hi,lo}=a*b unsigned, 2*WIDTH bits, no truncation.
//  DIVU: lo=a/b, hi=a%b. b==0: lo=all ones, hi=a, same latency, no error flag.
//  MFHI/MFLO issued right after DONE see the new hi/lo.
//  in_valid while in_ready=0: ignored, not queued; operands must be re-presented.
//  Operands and op latched at accept; a/b may change during iteration without effect.
//  ovf: ADD set when a,b same sign and sum sign differs; SUB when a,b differ and diff sign != a sign.
//  Illegal op: y=0, zero=1, ovf=0, out_valid next cycle, hi/lo unchanged.
//  rst mid-iteration: abort on that edge, all reset values; hi/lo not written with partial results.
//  rst has priority over a simultaneous accept.
// CONFIGURATION
//  ALU_SIGNED_MD_EN defined: ops A/B do signed MULT/DIV via magnitude iteration + FIX state.
//   FIX negates product/quotient if a,b signs differ; remainder takes sign of a. Latency WIDTH+2.
//   Signed DIV by 0: lo=all ones, hi=a. Most-negative/-1: lo=most-negative, hi=0.
//  Undefined: A/B decode as illegal op; FIX state and sign logic not synthesised.
// TESTING
//  ADD a=0x7FFFFFFF b=1 -> next cycle y=0x80000000, ovf=1, zero=0, out_valid=1.
//  SUB a=5 b=5 then SLTU a=1 b=2 on consecutive cycles -> y=0 zero=1, then y=1; in_ready held 1.
//  MULTU a=b=0xFFFFFFFF -> out_valid at cycle 33, hi=0xFFFFFFFE lo=0x00000001; in_ready=0 cycles 1-33.
//  DIVU 100/7 -> lo=14 hi=2; DIVU 9/0 -> lo=0xFFFFFFFF hi=9; MFHI next -> y=9.
//  MULTU started, rst at iteration 10 -> next cycle in_ready=1, out_valid=0, hi=lo=0; no late out_valid.
//  ALU_SIGNED_MD_EN: MULT -3*5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1 at cycle 34; DIV -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: EX-stage ALU with registered result, valid/ready input and iterative MUL/DIV into HI/LO; define ALU_SIGNED_MD_EN to add signed MULT/DIV (ops A/B)
module alu_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ovf,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef ALU_SIGNED_MD_EN
   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, MUL, DIV, DONE} state_t;
`endif
   state_t state, nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] wh, wl, md, nh, nl, ma, mb, res, sum, dif;
   logic [WIDTH:0] msum, dsh;
   logic start_mul, start_div, accept, last, fin, ovf_c;
   assign in_ready = state == IDLE;
   assign accept = in_valid && in_ready;
   assign last = cnt == CNT_W'(1);
   assign sum = a + b;
   assign dif = a + ~b + WIDTH'(1);
`ifdef ALU_SIGNED_MD_EN
   logic sop, sg, dv, np, nr, bz;
   logic [2*WIDTH-1:0] pr;
   logic [WIDTH-1:0] fh, fl;
   assign sop = op == 4'hA || op == 4'hB;
   assign start_mul = op == 4'h8 || op == 4'hA;
   assign start_div = op == 4'h9 || op == 4'hB;
   assign ma = sop && a[WIDTH-1] ? -a : a;
   assign mb = sop && b[WIDTH-1] ? -b : b;
   assign fin = last && !sg;
   // Sign fix-up: negate product/quotient on differing signs, remainder follows dividend; divide-by-zero keeps all-ones quotient
   always_comb begin
      pr = np ? -{wh, wl} : {wh, wl};
      fh = dv ? (nr ? -wh : wh) : pr[2*WIDTH-1:WIDTH];
      fl = dv ? (np && !bz ? -wl : wl) : pr[WIDTH-1:0];
   end
`else
   assign start_mul = op == 4'h8;
   assign start_div = op == 4'h9;
   assign ma = a;
   assign mb = b;
   assign fin = last;
`endif
   // One shift-add multiply step or one restoring-divide step on the shared wh/wl working pair
   always_comb begin
      msum = {1'b0, wh} + (wl[0] ? {1'b0, md} : '0);
      dsh = {wh, wl[WIDTH-1]};
      nh = msum[WIDTH:1];
      nl = {msum[0], wl[WIDTH-1:1]};
      if (state == DIV) begin
         nh = dsh >= {1'b0, md} ? WIDTH'(dsh - {1'b0, md}) : dsh[WIDTH-1:0];
         nl = {wl[WIDTH-2:0], dsh >= {1'b0, md}};
      end
   end
   // Single-cycle result and signed overflow
   always_comb begin
      res = '0;
      ovf_c = 1'b0;
      case (op)
         4'h0: res = a & b;
         4'h1: res = a | b;
         4'h2: begin
            res = sum;
            ovf_c = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
         end
         4'h3: begin
            res = dif;
            ovf_c = a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1];
         end
         4'h4: res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         4'h5: res = ~(a | b);
         4'h6: res = a ^ b;
         4'h7: res = {{(WIDTH-1){1'b0}}, a < b};
         4'hC: res = hi;
         4'hD: res = lo;
         default: res = '0;
      endcase
   end
   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= nxt;
   end
   // Next state: iterate WIDTH times, optional sign fix-up, then one DONE cycle
   always_comb begin
      nxt = state;
      case (state)
         IDLE: nxt = !accept ? IDLE : start_mul ? MUL : start_div ? DIV : IDLE;
`ifdef ALU_SIGNED_MD_EN
         MUL, DIV: nxt = !last ? state : sg ? FIX : DONE;
         FIX: nxt = DONE;
`else
         MUL, DIV: nxt = last ? DONE : state;
`endif
         DONE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // Datapath: latch operands at accept, iterate, commit HI/LO and result on completion
   always_ff @(posedge clk) begin
      out_valid <= 1'b0;
      if (rst) begin
         y <= '0;
         zero <= 1'b0;
         ovf <= 1'b0;
         hi <= '0;
         lo <= '0;
         cnt <= '0;
         wh <= '0;
         wl <= '0;
         md <= '0;
`ifdef ALU_SIGNED_MD_EN
         {sg, dv, np, nr, bz} <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (accept) begin
               if (start_mul || start_div) begin
                  cnt <= CNT_W'(WIDTH);
                  wh <= '0;
                  wl <= start_mul ? mb : ma;
                  md <= start_mul ? ma : mb;
`ifdef ALU_SIGNED_MD_EN
                  sg <= sop;
                  dv <= start_div;
                  np <= a[WIDTH-1] ^ b[WIDTH-1];
                  nr <= a[WIDTH-1];
                  bz <= b == '0;
`endif
               end else begin
                  y <= res;
                  zero <= res == '0;
                  ovf <= ovf_c;
                  out_valid <= 1'b1;
               end
            end
            MUL, DIV: begin
               wh <= nh;
               wl <= nl;
               cnt <= cnt - CNT_W'(1);
               if (fin) begin
                  hi <= nh;
                  lo <= nl;
                  y <= nl;
                  zero <= nl == '0;
                  ovf <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
`ifdef ALU_SIGNED_MD_EN
            FIX: begin
               hi <= fh;
               lo <= fl;
               y <= fl;
               zero <= fl == '0;
               ovf <= 1'b0;
               out_valid <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed self-checking bench for alu_muldiv_seq (WIDTH=32)
module tb_alu_muldiv_seq;
   logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, zero, ovf;
   logic [3:0] op = 0;
   logic [31:0] a = 0, b = 0, y, hi, lo;
   int checks = 0, errors = 0;

   alu_muldiv_seq dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .y(y), .zero(zero), .ovf(ovf), .hi(hi), .lo(lo));

   always #5 clk = ~clk;

   task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
      op = o; a = x; b = z; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (y !== 0 || zero !== 0 || ovf !== 0) begin errors++; $display("FAIL reset_y: y=%h zero=%b ovf=%b want 0 0 0", y, zero, ovf); end
      checks++; if (out_valid !== 0 || in_ready !== 1) begin errors++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
      checks++; if (hi !== 0 || lo !== 0) begin errors++; $display("FAIL reset_hilo: hi=%h lo=%h want 0 0", hi, lo); end
      rst = 0;
   endtask

   task automatic test_arith;
      drive(4'h2, 32'h7FFFFFFF, 32'h1);
      checks++; if (y !== 32'h80000000 || ovf !== 1 || zero !== 0 || out_valid !== 1) begin errors++; $display("FAIL add_ovf: y=%h ovf=%b zero=%b ov=%b want 80000000 1 0 1", y, ovf, zero, out_valid); end
      drive(4'h3, 32'h80000000, 32'h1);
      checks++; if (y !== 32'h7FFFFFFF || ovf !== 1) begin errors++; $display("FAIL sub_ovf: y=%h ovf=%b want 7fffffff 1", y, ovf); end
      drive(4'h2, 32'hFFFFFFFF, 32'h1);
      checks++; if (y !== 0 || ovf !== 0 || zero !== 1) begin errors++; $display("FAIL add_wrap: y=%h ovf=%b zero=%b want 0 0 1", y, ovf, zero); end
      drive(4'h4, 32'hFFFFFFFF, 32'h1);
      checks++; if (y !== 1) begin errors++; $display("FAIL slt: y=%h want 1", y); end
      drive(4'h7, 32'hFFFFFFFF, 32'h1);
      checks++; if (y !== 0 || zero !== 1) begin errors++; $display("FAIL sltu: y=%h zero=%b want 0 1", y, zero); end
   endtask

   task automatic test_logic;
      drive(4'h0, 32'h0000F0F0, 32'h0000FF00);
      checks++; if (y !== 32'h0000F000 || ovf !== 0) begin errors++; $display("FAIL and: y=%h ovf=%b want 0000f000 0", y, ovf); end
      drive(4'h1, 32'h0000F0F0, 32'h0000FF00);
      checks++; if (y !== 32'h0000FFF0) begin errors++; $display("FAIL or: y=%h want 0000fff0", y); end
      drive(4'h5, 32'h0, 32'h0);
      checks++; if (y !== 32'hFFFFFFFF || zero !== 0) begin errors++; $display("FAIL nor: y=%h zero=%b want ffffffff 0", y, zero); end
      drive(4'h6, 32'hFF, 32'h0F);
      checks++; if (y !== 32'hF0) begin errors++; $display("FAIL xor: y=%h want f0", y); end
   endtask

   task automatic test_back_to_back;
      op = 4'h3; a = 5; b = 5; in_valid = 1;
      @(posedge clk); #1;
      checks++; if (y !== 0 || zero !== 1 || out_valid !== 1 || in_ready !== 1) begin errors++; $display("FAIL b2b_sub: y=%h zero=%b ov=%b rdy=%b want 0 1 1 1", y, zero, out_valid, in_ready); end
      op = 4'h7; a = 1; b = 2;
      @(posedge clk); #1;
      in_valid = 0;
      checks++; if (y !== 1 || zero !== 0 || out_valid !== 1 || in_ready !== 1) begin errors++; $display("FAIL b2b_sltu: y=%h zero=%b ov=%b rdy=%b want 1 0 1 1", y, zero, out_valid, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 0) begin errors++; $display("FAIL b2b_pulse: out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_multu;
      int bad_rdy = 0, early = 0;
      drive(4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF);
      for (int c = 1; c <= 33; c++) begin
         if (c == 3) begin op = 4'h2; a = 0; b = 0; in_valid = 1; end
         if (c == 5) in_valid = 0;
         if (in_ready !== 0) bad_rdy++;
         if (c < 33 && out_valid !== 0) early++;
         if (c < 33) begin @(posedge clk); #1; end
      end
      checks++; if (bad_rdy !== 0 || early !== 0) begin errors++; $display("FAIL multu_busy: rdy_high=%0d early_valid=%0d want 0 0", bad_rdy, early); end
      checks++; if (out_valid !== 1 || hi !== 32'hFFFFFFFE || lo !== 32'h1 || y !== 32'h1) begin errors++; $display("FAIL multu_c33: ov=%b hi=%h lo=%h y=%h want 1 fffffffe 00000001 00000001", out_valid, hi, lo, y); end
      @(posedge clk); #1;
      checks++; if (in_ready !== 1 || out_valid !== 0) begin errors++; $display("FAIL multu_after: rdy=%b ov=%b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_divu;
      int cyc;
      drive(4'h9, 100, 7);
      wait_done(cyc);
      checks++; if (cyc !== 33 || lo !== 14 || hi !== 2) begin errors++; $display("FAIL divu: cyc=%0d lo=%0d hi=%0d want 33 14 2", cyc, lo, hi); end
      @(posedge clk); #1;
      drive(4'h9, 9, 0);
      wait_done(cyc);
      checks++; if (cyc !== 33 || lo !== 32'hFFFFFFFF || hi !== 9) begin errors++; $display("FAIL divu_zero: cyc=%0d lo=%h hi=%h want 33 ffffffff 9", cyc, lo, hi); end
      @(posedge clk); #1;
      drive(4'hC, 0, 0);
      checks++; if (y !== 9 || out_valid !== 1) begin errors++; $display("FAIL mfhi: y=%h ov=%b want 9 1", y, out_valid); end
      drive(4'hD, 0, 0);
      checks++; if (y !== 32'hFFFFFFFF) begin errors++; $display("FAIL mflo: y=%h want ffffffff", y); end
   endtask

   task automatic test_illegal;
      int cyc;
      drive(4'h8, 3, 5);
      wait_done(cyc);
      checks++; if (cyc !== 33 || hi !== 0 || lo !== 15) begin errors++; $display("FAIL multu_small: cyc=%0d hi=%h lo=%h want 33 0 f", cyc, hi, lo); end
      @(posedge clk); #1;
      drive(4'hF, 32'h1234, 32'h5678);
      checks++; if (y !== 0 || zero !== 1 || ovf !== 0 || out_valid !== 1) begin errors++; $display("FAIL illegal: y=%h zero=%b ovf=%b ov=%b want 0 1 0 1", y, zero, ovf, out_valid); end
      checks++; if (hi !== 0 || lo !== 15) begin errors++; $display("FAIL illegal_hilo: hi=%h lo=%h want 0 f", hi, lo); end
   endtask

   task automatic test_signed;
      int cyc;
`ifdef ALU_SIGNED_MD_EN
      drive(4'hA, 32'hFFFFFFFD, 5);
      wait_done(cyc);
      checks++; if (cyc !== 34 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult: cyc=%0d hi=%h lo=%h want 34 ffffffff fffffff1", cyc, hi, lo); end
      @(posedge clk); #1;
      drive(4'hB, 32'hFFFFFFF9, 2);
      wait_done(cyc);
      checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div: lo=%h hi=%h want fffffffd ffffffff", lo, hi); end
      @(posedge clk); #1;
`else
      drive(4'hA, 32'hFFFFFFFD, 5);
      cyc = 0;
      checks++; if (y !== 0 || zero !== 1 || out_valid !== 1 || in_ready !== 1) begin errors++; $display("FAIL op_a_illegal: y=%h zero=%b ov=%b rdy=%b want 0 1 1 1", y, zero, out_valid, in_ready); end
`endif
   endtask

   task automatic test_reset_mid;
      int late = 0;
      drive(4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (9) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      checks++; if (in_ready !== 1 || out_valid !== 0 || hi !== 0 || lo !== 0) begin errors++; $display("FAIL rst_mid: rdy=%b ov=%b hi=%h lo=%h want 1 0 0 0", in_ready, out_valid, hi, lo); end
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (out_valid !== 0) late++;
      end
      checks++; if (late !== 0) begin errors++; $display("FAIL rst_late_valid: pulses=%0d want 0", late); end
   endtask

   initial begin
      test_reset;
      test_arith;
      test_logic;
      test_back_to_back;
      test_multu;
      test_divu;
      test_illegal;
      test_signed;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
